// File: rtl/throughout_or_pkg.sv
// ============================================================================
// throughout_or_pkg : shared types, encodings and helpers for the checker
// Revision: 1.0
// ============================================================================
`default_nettype none

package throughout_or_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam logic CAUSE_GUARD   = 1'b0;
   localparam logic CAUSE_TIMEOUT = 1'b1;

   // Effective window: 0 behaves as 1, anything past win_max saturates.
   function automatic int unsigned clamp_win(input int unsigned len,
                                             input int unsigned win_max);
      if (len == 0)
         return 1;
      else if (len > win_max)
         return win_max;
      else
         return len;
   endfunction

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++)
         n += int'(v[i]);
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tor_channel.sv
// ============================================================================
// tor_channel : one "guard throughout (A or B)" attempt FSM with registered results
// Revision: 1.0
// ============================================================================
`default_nettype none

module tor_channel
   import throughout_or_pkg::*;
#(
   parameter int unsigned WIN_MAX = 16,
   parameter int unsigned WL_W    = $clog2(WIN_MAX + 1),
   parameter int unsigned LAT_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WL_W-1:0]  win_len,
   input  logic             start,
   input  logic             guard,
   input  logic             ev_a,
   input  logic             ev_b,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic             cause,
   output logic [1:0]       hit,
   output logic [LAT_W-1:0] lat,
   output logic             drop
);

   state_t           state_q, state_d;
   logic [LAT_W-1:0] k_q, k_d;
   logic [LAT_W-1:0] last_q, last_d;
   logic             busy_q, busy_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             cause_q, cause_d;
   logic [1:0]       hit_q, hit_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             drop_q, drop_d;

   logic [LAT_W-1:0] last_start;
   logic [LAT_W-1:0] k_cur;
   logic [LAT_W-1:0] last_cur;
   logic             evaluate;
   logic             resolved;

   // Stored as W-1 so the timeout test is a plain equality against k.
   assign last_start = LAT_W'(clamp_win(32'(win_len), WIN_MAX) - 1);

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      last_d   = last_q;
      pass_d   = 1'b0;
      fail_d   = 1'b0;
      cause_d  = 1'b0;
      hit_d    = 2'b00;
      lat_d    = '0;
      drop_d   = 1'b0;
      evaluate = 1'b0;
      resolved = 1'b0;
      k_cur    = k_q;
      last_cur = last_q;

      if (state_q == IDLE) begin
         evaluate = start;
         k_cur    = '0;
         last_cur = last_start;
      end else begin
         evaluate = 1'b1;
         drop_d   = start;
      end

      if (evaluate) begin
         if (!guard) begin
            fail_d   = 1'b1;
            cause_d  = CAUSE_GUARD;
            resolved = 1'b1;
         end else if (ev_a || ev_b) begin
            pass_d   = 1'b1;
            hit_d    = {ev_b, ev_a};
            lat_d    = k_cur;
            resolved = 1'b1;
         end else if (k_cur == last_cur) begin
            fail_d   = 1'b1;
            cause_d  = CAUSE_TIMEOUT;
            resolved = 1'b1;
         end
      end

      if (resolved) begin
         state_d = IDLE;
      end else if (evaluate) begin
         state_d = ACTIVE;
         k_d     = k_cur + LAT_W'(1);
         last_d  = last_cur;
      end

      busy_d = (state_d == ACTIVE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
         cause_q <= 1'b0;
         hit_q   <= 2'b00;
         lat_q   <= '0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         cause_q <= cause_d;
         hit_q   <= hit_d;
         lat_q   <= lat_d;
         drop_q  <= drop_d;
      end
   end

   assign busy  = busy_q;
   assign pass  = pass_q;
   assign fail  = fail_q;
   assign cause = cause_q;
   assign hit   = hit_q;
   assign lat   = lat_q;
   assign drop  = drop_q;

endmodule

`default_nettype wire

// File: rtl/throughout_or_checker.sv
// ============================================================================
// throughout_or_checker : CH-channel first-match checker with saturating totals
// Revision: 1.0
// ============================================================================
`default_nettype none

module throughout_or_checker
   import throughout_or_pkg::*;
#(
   parameter int unsigned CH      = 4,
   parameter int unsigned WIN_MAX = 16,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned WL_W    = $clog2(WIN_MAX + 1),
   parameter int unsigned LAT_W   = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WL_W-1:0]     win_len,
   input  logic [CH-1:0]       start,
   input  logic [CH-1:0]       guard,
   input  logic [CH-1:0]       ev_a,
   input  logic [CH-1:0]       ev_b,
   input  logic                clr_cnt,
   output logic [CH-1:0]       busy,
   output logic [CH-1:0]       pass,
   output logic [CH-1:0]       fail,
   output logic [CH-1:0]       cause,
   output logic [2*CH-1:0]     hit,
   output logic [CH*LAT_W-1:0] lat,
   output logic [CH-1:0]       drop,
   output logic [CNT_W-1:0]    pass_cnt,
   output logic [CNT_W-1:0]    fail_cnt
);

   localparam int unsigned SUM_W = CNT_W + 7;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      tor_channel #(
         .WIN_MAX (WIN_MAX),
         .WL_W    (WL_W),
         .LAT_W   (LAT_W)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .win_len (win_len),
         .start   (start[i]),
         .guard   (guard[i]),
         .ev_a    (ev_a[i]),
         .ev_b    (ev_b[i]),
         .busy    (busy[i]),
         .pass    (pass[i]),
         .fail    (fail[i]),
         .cause   (cause[i]),
         .hit     (hit[2*i +: 2]),
         .lat     (lat[i*LAT_W +: LAT_W]),
         .drop    (drop[i])
      );
   end

   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [SUM_W-1:0] pass_sum;
   logic [SUM_W-1:0] fail_sum;

   // Wide sums so the saturation test never sees a wrapped value.
   always_comb begin
      pass_sum = SUM_W'(pass_cnt_q) + SUM_W'(popcount(32'(pass)));
      fail_sum = SUM_W'(fail_cnt_q) + SUM_W'(popcount(32'(fail)));

      if (clr_cnt)
         pass_cnt_d = '0;
      else if (pass_sum > SUM_W'({CNT_W{1'b1}}))
         pass_cnt_d = '1;
      else
         pass_cnt_d = pass_sum[CNT_W-1:0];

      if (clr_cnt)
         fail_cnt_d = '0;
      else if (fail_sum > SUM_W'({CNT_W{1'b1}}))
         fail_cnt_d = '1;
      else
         fail_cnt_d = fail_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   assign pass_cnt = pass_cnt_q;
   assign fail_cnt = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_throughout_or_checker.sv
// ============================================================================
// tb_throughout_or_checker : directed self-checking bench, CH=4 / CNT_W=3
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_throughout_or_checker;

   localparam int CH      = 4;
   localparam int WIN_MAX = 16;
   localparam int CNT_W   = 3;
   localparam int WL_W    = 5;
   localparam int LAT_W   = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic [WL_W-1:0]     win_len;
   logic [CH-1:0]       start, guard, ev_a, ev_b;
   logic                clr_cnt;
   logic [CH-1:0]       busy, pass, fail, cause, drop;
   logic [2*CH-1:0]     hit;
   logic [CH*LAT_W-1:0] lat;
   logic [CNT_W-1:0]    pass_cnt, fail_cnt;

   int checks = 0;
   int errors = 0;

   throughout_or_checker #(
      .CH      (CH),
      .WIN_MAX (WIN_MAX),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .win_len  (win_len),
      .start    (start),
      .guard    (guard),
      .ev_a     (ev_a),
      .ev_b     (ev_b),
      .clr_cnt  (clr_cnt),
      .busy     (busy),
      .pass     (pass),
      .fail     (fail),
      .cause    (cause),
      .hit      (hit),
      .lat      (lat),
      .drop     (drop),
      .pass_cnt (pass_cnt),
      .fail_cnt (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; win_len = '0; start = '0; guard = '0;
      ev_a = '0; ev_b = '0; clr_cnt = 1'b0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_fail", 32'(fail), 0);
      chk("rst_hit", 32'(hit), 0);
      chk("rst_pcnt", 32'(pass_cnt), 0);
      chk("rst_fcnt", 32'(fail_cnt), 0);
      rst = 1'b0;
      tick();

      // ev_b at k=2, window 4
      guard = 4'b0001; win_len = 5'd4; start = 4'b0001;
      tick();
      start = '0;
      chk("t1_busy_k1", 32'(busy), 32'h1);
      chk("t1_nopass", 32'(pass), 0);
      tick();
      ev_b = 4'b0001;
      tick();
      chk("t1_pass", 32'(pass), 32'h1);
      chk("t1_hit", 32'(hit[1:0]), 32'h2);
      chk("t1_lat", 32'(lat[3:0]), 32'h2);
      chk("t1_busy_low", 32'(busy), 0);
      ev_b = '0;
      tick();
      chk("t1_pulse_one", 32'(pass), 0);
      chk("t1_pcnt", 32'(pass_cnt), 1);

      // guard low in start cycle beats ev_a
      guard = '0; ev_a = 4'b0001; start = 4'b0001;
      tick();
      start = '0; ev_a = '0;
      chk("t2_fail", 32'(fail), 32'h1);
      chk("t2_cause", 32'(cause), 0);
      chk("t2_nopass", 32'(pass), 0);
      tick();
      chk("t2_fcnt", 32'(fail_cnt), 1);

      // guard drops at k=3 of 8
      guard = 4'b0001; win_len = 5'd8; start = 4'b0001;
      tick();
      start = '0;
      tick(); tick();
      chk("t3_nofail_k2", 32'(fail), 0);
      guard = '0;
      tick();
      chk("t3_fail", 32'(fail), 32'h1);
      chk("t3_cause", 32'(cause), 0);
      guard = 4'b0001;
      tick();
      chk("t3_fcnt", 32'(fail_cnt), 2);

      // timeout, window 5
      win_len = 5'd5; start = 4'b0001;
      tick();
      start = '0;
      tick(); tick(); tick();
      chk("t4_nofail_k3", 32'(fail), 0);
      tick();
      chk("t4_fail", 32'(fail), 32'h1);
      chk("t4_cause", 32'(cause), 32'h1);
      tick();
      chk("t4_fcnt", 32'(fail_cnt), 3);

      // win_len 0 behaves as 1
      win_len = 5'd0; start = 4'b0001;
      tick();
      start = '0;
      chk("t5_fail", 32'(fail), 32'h1);
      chk("t5_cause", 32'(cause), 32'h1);
      chk("t5_busy", 32'(busy), 0);
      tick();

      // win_len 19 clamped to 16
      win_len = 5'd19; start = 4'b0001;
      tick();
      start = '0;
      for (int i = 0; i < 14; i++) tick();
      chk("t6_nofail_k14", 32'(fail), 0);
      chk("t6_busy_k14", 32'(busy), 32'h1);
      tick();
      chk("t6_fail", 32'(fail), 32'h1);
      chk("t6_cause", 32'(cause), 32'h1);
      tick();
      chk("t6_fcnt", 32'(fail_cnt), 5);

      // both alternatives at k=0, then back-to-back start
      win_len = 5'd4; ev_a = 4'b0001; ev_b = 4'b0001; start = 4'b0001;
      tick();
      ev_b = '0;
      chk("t7_pass", 32'(pass), 32'h1);
      chk("t7_hit", 32'(hit[1:0]), 32'h3);
      chk("t7_lat", 32'(lat[3:0]), 0);
      chk("t7_busy", 32'(busy), 0);
      tick();
      start = '0; ev_a = '0;
      chk("t7_pass2", 32'(pass), 32'h1);
      chk("t7_hit2", 32'(hit[1:0]), 32'h1);
      chk("t7_pcnt", 32'(pass_cnt), 2);
      tick();
      chk("t7_pcnt2", 32'(pass_cnt), 3);

      // starts during an active attempt are dropped
      win_len = 5'd8; start = 4'b0001;
      tick();
      tick();
      chk("t8_drop1", 32'(drop), 32'h1);
      tick();
      chk("t8_drop2", 32'(drop), 32'h1);
      start = '0; ev_a = 4'b0001;
      tick();
      ev_a = '0;
      chk("t8_nodrop", 32'(drop), 0);
      chk("t8_pass", 32'(pass), 32'h1);
      chk("t8_lat", 32'(lat[3:0]), 32'h3);
      tick();
      chk("t8_pcnt", 32'(pass_cnt), 4);

      // counter clear, all-channel increment, saturation
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      chk("t9_clr_p", 32'(pass_cnt), 0);
      chk("t9_clr_f", 32'(fail_cnt), 0);
      guard = 4'b1111; ev_a = 4'b1111; start = 4'b1111;
      tick();
      start = '0;
      chk("t9_pass4", 32'(pass), 32'hF);
      chk("t9_lat4", 32'(lat), 0);
      tick();
      chk("t9_pcnt4", 32'(pass_cnt), 4);
      start = 4'b1111;
      tick();
      start = '0;
      tick();
      chk("t9_sat", 32'(pass_cnt), 7);
      start = 4'b1111;
      tick();
      start = '0; clr_cnt = 1'b1;
      chk("t9_pass_clr", 32'(pass), 32'hF);
      tick();
      clr_cnt = 1'b0; ev_a = '0;
      chk("t9_clr_win", 32'(pass_cnt), 0);

      // reset mid-attempt
      guard = 4'b0001; start = 4'b0001; win_len = 5'd8;
      tick();
      start = '0;
      tick();
      chk("t10_busy_pre", 32'(busy), 32'h1);
      rst = 1'b1;
      #1;
      chk("t10_busy", 32'(busy), 0);
      chk("t10_out", 32'({pass, fail, cause, hit, drop, lat}), 0);
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("t10_nopulse", 32'({pass, fail, busy}), 0);
      chk("t10_cnt", 32'({pass_cnt, fail_cnt}), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
